// File: rtl/eth_pkt_tx.sv
// ----------------------------------------------------------------------------
// eth_pkt_tx
// Host-side store-and-forward packet transmitter for one switch input port.
// Host words are buffered until the whole packet (through in_last) is stored.
// Only then is the packet launched on the port. Every packet therefore leaves
// as an unbroken run of words framed by o_start / o_end.
//
// Ports
//   clk       : clock
//   rst       : synchronous reset, active-high
//   in_valid  : host word valid
//   in_data   : host word
//   in_last   : host word is the last word of its packet
//   in_ready  : host word accepted when in_valid && in_ready at a clk edge
//   stall     : port backpressure, only blocks the start of a packet
//   o_data    : port data, 0 when idle
//   o_start   : first word of a packet
//   o_end     : last word of a packet
//   pkt_cnt   : complete packets stored and not yet finished sending
//   drop      : one-cycle pulse when an oversize packet is discarded
//
// Configuration
//   ETH_PKT_TX_IFG_EN : when defined, a GAP state holds the port idle for
//                       IFG_CYCLES cycles after every o_end.
// ----------------------------------------------------------------------------
module eth_pkt_tx #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 32,
    parameter int IFG_CYCLES = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_last,
    output logic                       in_ready,
    input  logic                       stall,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_start,
    output logic                       o_end,
    output logic [$clog2(DEPTH):0]     pkt_cnt,
    output logic                       drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW:0]   PTR_ONE = {{PW{1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    // Elaboration-time sanity checks on the parameters.
    if (DEPTH < 2 || (1 << PW) != DEPTH) begin : g_bad_depth
        $error("eth_pkt_tx: DEPTH must be a power of 2 and >= 2");
    end
    if (IFG_CYCLES < 1) begin : g_bad_ifg
        $error("eth_pkt_tx: IFG_CYCLES must be >= 1");
    end

`ifdef ETH_PKT_TX_IFG_EN
    localparam int GW = $clog2(IFG_CYCLES + 1);
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SEND} state_t;
`endif

    state_t          state_q, state_d;
    logic            first_q, first_d;
    logic [PW:0]     wr_ptr_q, wr_ptr_d;
    logic [PW:0]     rd_ptr_q, rd_ptr_d;
    logic [PW:0]     sop_ptr_q, sop_ptr_d;
    logic [CW-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic            discard_q, discard_d;
    logic            drop_q, drop_d;

    // Each buffer entry carries its in_last flag in the top bit so the read
    // side knows where the stored packet ends.
    logic [WIDTH:0]  mem_q [DEPTH];
    logic            mem_we;
    logic [PW-1:0]   mem_waddr;
    logic [WIDTH:0]  mem_wdata;
    logic [WIDTH:0]  rd_word;

    logic            full;
    logic            accept;
    logic            pkt_inc;
    logic            pkt_dec;

    // Pointers carry one extra wrap bit: equal index with differing wrap bits
    // means the buffer holds exactly DEPTH words.
    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign rd_word = mem_q[rd_ptr_q[PW-1:0]];

    // When full with no complete packet stored, the packet being written can
    // never fit, so the input stays open to let it be discarded.
    assign in_ready = discard_q || !full || (pkt_cnt_q == '0);
    assign accept   = in_valid && in_ready;
    assign pkt_cnt  = pkt_cnt_q;
    assign drop     = drop_q;

    // Write side: store words, track start of the current packet, and on
    // overflow rewind to that start and swallow the rest of the packet.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        sop_ptr_d = sop_ptr_q;
        discard_d = discard_q;
        drop_d    = 1'b0;
        pkt_inc   = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = wr_ptr_q[PW-1:0];
        mem_wdata = {in_last, in_data};
        if (accept) begin
            if (discard_q) begin
                if (in_last) begin
                    discard_d = 1'b0;
                end
            end else if (full) begin
                wr_ptr_d  = sop_ptr_q;
                drop_d    = 1'b1;
                discard_d = !in_last;
            end else begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                if (in_last) begin
                    sop_ptr_d = wr_ptr_q + PTR_ONE;
                    pkt_inc   = 1'b1;
                end
            end
        end
    end

    // Read side FSM: launch a stored packet when the port is not stalled,
    // then stream it word by word until its stored last flag.
    always_comb begin
        state_d  = state_q;
        first_d  = 1'b0;
        rd_ptr_d = rd_ptr_q;
        pkt_dec  = 1'b0;
        o_data   = '0;
        o_start  = 1'b0;
        o_end    = 1'b0;
`ifdef ETH_PKT_TX_IFG_EN
        gap_cnt_d = gap_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pkt_cnt_q != '0 && !stall) begin
                    state_d = ST_SEND;
                    first_d = 1'b1;
                end
            end
            ST_SEND: begin
                o_data   = rd_word[WIDTH-1:0];
                o_start  = first_q;
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                if (rd_word[WIDTH]) begin
                    o_end   = 1'b1;
                    pkt_dec = 1'b1;
`ifdef ETH_PKT_TX_IFG_EN
                    state_d   = ST_GAP;
                    gap_cnt_d = GW'(IFG_CYCLES - 1);
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef ETH_PKT_TX_IFG_EN
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stored-packet count: a packet completing on input and one finishing on
    // output in the same cycle cancel out.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        case ({pkt_inc, pkt_dec})
            2'b10:   pkt_cnt_d = pkt_cnt_q + CNT_ONE;
            2'b01:   pkt_cnt_d = pkt_cnt_q - CNT_ONE;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            first_q   <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            sop_ptr_q <= '0;
            pkt_cnt_q <= '0;
            discard_q <= 1'b0;
            drop_q    <= 1'b0;
`ifdef ETH_PKT_TX_IFG_EN
            gap_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            first_q   <= first_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            sop_ptr_q <= sop_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
            discard_q <= discard_d;
            drop_q    <= drop_d;
`ifdef ETH_PKT_TX_IFG_EN
            gap_cnt_q <= gap_cnt_d;
`endif
        end
    end

    // Buffer storage needs no reset: the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_eth_pkt_tx.sv
// ----------------------------------------------------------------------------
// tb_eth_pkt_tx
// Self-checking bench for eth_pkt_tx. The reference model is a list of
// expected packets: every packet of at most DEPTH words must come out intact
// and in order, longer packets vanish with one drop pulse each.
// ----------------------------------------------------------------------------
module tb_eth_pkt_tx;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef ETH_PKT_TX_IFG_EN
    localparam int EXP_GAP = 3 + 1;
`else
    localparam int EXP_GAP = 1;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_ready;
    logic             stall;
    logic [WIDTH-1:0] o_data;
    logic             o_start;
    logic             o_end;
    logic [CW-1:0]    pkt_cnt;
    logic             drop;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: expected packets, flattened words plus lengths.
    logic [WIDTH-1:0] exp_words[$];
    int               exp_lens[$];

    // Observed packets collected by the monitor.
    logic [WIDTH-1:0] rx_words[$];
    int               rx_lens[$];

    int  cyc          = 0;
    bit  mon_in_pkt   = 0;
    int  mon_len      = 0;
    int  last_end_cyc = -1;
    int  last_gap     = -1;
    int  min_gap      = 1000;
    int  proto_err    = 0;
    int  drop_cnt     = 0;
    bit  drv_timeout  = 0;
    bit  ready_low    = 0;
    bit  rand_stall_en = 0;

    eth_pkt_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IFG_CYCLES(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .stall    (stall),
        .o_data   (o_data),
        .o_start  (o_start),
        .o_end    (o_end),
        .pkt_cnt  (pkt_cnt),
        .drop     (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: rebuilds packets from the port framing and notes spacing,
    // framing errors and drop pulses.
    always @(negedge clk) begin
        if (rst) begin
            mon_in_pkt   = 0;
            mon_len      = 0;
            last_end_cyc = -1;
        end else begin
            if (o_start) begin
                if (mon_in_pkt) proto_err++;
                if (last_end_cyc >= 0) begin
                    last_gap = cyc - last_end_cyc - 1;
                    if (last_gap < min_gap) min_gap = last_gap;
                end
                mon_in_pkt = 1;
                mon_len    = 0;
            end
            if (mon_in_pkt) begin
                rx_words.push_back(o_data);
                mon_len++;
                if (o_end) begin
                    rx_lens.push_back(mon_len);
                    mon_in_pkt   = 0;
                    last_end_cyc = cyc;
                end
            end else if (o_end || o_data !== '0) begin
                proto_err++;
            end
            if (drop) drop_cnt++;
        end
    end

    // Random port backpressure used by the randomized scenario.
    always @(negedge clk) begin
        if (rand_stall_en) stall = ($urandom_range(0, 3) == 0);
    end

    // Whole-run guard against a hung simulation.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drives one word from a negedge, waits (bounded) for in_ready, and
    // returns at the negedge after the accepting edge.
    task automatic push_word(input logic [WIDTH-1:0] d, input logic l);
        int waits;
        waits    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && waits < 500) begin
            ready_low = 1;
            @(negedge clk);
            waits++;
        end
        if (!in_ready) drv_timeout = 1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    // Sends a packet of random words and records what the model expects.
    task automatic push_pkt(input int len, input bit rand_gaps);
        logic [WIDTH-1:0] w;
        for (int i = 0; i < len; i++) begin
            if (rand_gaps && $urandom_range(0, 3) == 0) @(negedge clk);
            w = $urandom;
            push_word(w, i == len - 1);
            if (len <= DEPTH) exp_words.push_back(w);
        end
        if (len <= DEPTH) exp_lens.push_back(len);
    endtask

    task automatic wait_drain(output bit ok);
        int n;
        n = 0;
        while (rx_lens.size() != exp_lens.size() && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        ok = (rx_lens.size() == exp_lens.size()) && !mon_in_pkt;
    endtask

    task automatic clear_model();
        exp_words.delete();
        exp_lens.delete();
        rx_words.delete();
        rx_lens.delete();
    endtask

    function automatic int count_diffs();
        int d;
        d = 0;
        if (rx_lens.size() != exp_lens.size()) d++;
        if (rx_words.size() != exp_words.size()) d++;
        for (int i = 0; i < rx_lens.size() && i < exp_lens.size(); i++)
            if (rx_lens[i] != exp_lens[i]) d++;
        for (int i = 0; i < rx_words.size() && i < exp_words.size(); i++)
            if (rx_words[i] !== exp_words[i]) d++;
        return d;
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; stall = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (o_data !== '0) begin tests_failed++; $display("[TB] FAIL reset_o_data: got %h want 0", o_data); end
        tests_run++;
        if (o_start !== 1'b0 || o_end !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_framing: got start=%b end=%b want 0 0", o_start, o_end); end
        tests_run++;
        if (drop !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_drop: got %b want 0", drop); end
        tests_run++;
        if (pkt_cnt !== '0) begin tests_failed++; $display("[TB] FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt); end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic_packet();
        bit ok;
        clear_model();
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_word(32'h000000A0 + i, i == 3);
            exp_words.push_back(32'h000000A0 + i);
        end
        exp_lens.push_back(4);
        tests_run++;
        if (pkt_cnt !== 1 || o_start !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_stored: got cnt=%0d start=%b want cnt=1 start=0", pkt_cnt, o_start); end
        @(negedge clk);
        tests_run++;
        if (o_start !== 1'b1 || o_data !== 32'h000000A0) begin tests_failed++; $display("[TB] FAIL basic_first_word: got start=%b data=%h want 1 000000a0", o_start, o_data); end
        wait_drain(ok);
        tests_run++;
        if (!ok || count_diffs() !== 0) begin tests_failed++; $display("[TB] FAIL basic_packet: got %0d diffs drained=%b want 0 diffs drained=1", count_diffs(), ok); end
        tests_run++;
        if (pkt_cnt !== '0) begin tests_failed++; $display("[TB] FAIL basic_cnt_after: got %0d want 0", pkt_cnt); end
    endtask

    task automatic test_single_word();
        bit ok;
        clear_model();
        stall = 1'b1;
        push_word(32'h0000DEAD, 1'b1);
        exp_words.push_back(32'h0000DEAD);
        exp_lens.push_back(1);
        tests_run++;
        if (pkt_cnt !== 1) begin tests_failed++; $display("[TB] FAIL single_stored: got %0d want 1", pkt_cnt); end
        stall = 1'b0;
        @(negedge clk);
        tests_run++;
        if (o_start !== 1'b1 || o_end !== 1'b1 || o_data !== 32'h0000DEAD) begin tests_failed++; $display("[TB] FAIL single_word: got start=%b end=%b data=%h want 1 1 0000dead", o_start, o_end, o_data); end
        @(negedge clk);
        tests_run++;
        if (o_start !== 1'b0 || o_data !== '0 || pkt_cnt !== '0) begin tests_failed++; $display("[TB] FAIL single_after: got start=%b data=%h cnt=%0d want 0 0 0", o_start, o_data, pkt_cnt); end
        wait_drain(ok);
        tests_run++;
        if (!ok || count_diffs() !== 0) begin tests_failed++; $display("[TB] FAIL single_packet: got %0d diffs want 0", count_diffs()); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int starts;
        clear_model();
        stall = 1'b1;
        push_pkt(3, 0);
        push_pkt(3, 0);
        tests_run++;
        if (pkt_cnt !== 2) begin tests_failed++; $display("[TB] FAIL b2b_stored: got %0d want 2", pkt_cnt); end
        starts = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (o_start) starts++;
        end
        tests_run++;
        if (starts !== 0) begin tests_failed++; $display("[TB] FAIL stall_hold: got %0d starts want 0", starts); end
        stall = 1'b0;
        @(negedge clk);
        tests_run++;
        if (o_start !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_release: got start=%b want 1", o_start); end
        wait_drain(ok);
        tests_run++;
        if (!ok || count_diffs() !== 0) begin tests_failed++; $display("[TB] FAIL b2b_packets: got %0d diffs want 0", count_diffs()); end
        tests_run++;
        if (last_gap !== EXP_GAP) begin tests_failed++; $display("[TB] FAIL b2b_gap: got %0d idle cycles want %0d", last_gap, EXP_GAP); end

        // Stall raised while a packet is on the port must not cut it short.
        clear_model();
        push_pkt(6, 0);
        @(negedge clk);
        tests_run++;
        if (o_start !== 1'b1) begin tests_failed++; $display("[TB] FAIL midstall_start: got start=%b want 1", o_start); end
        stall = 1'b1;
        wait_drain(ok);
        tests_run++;
        if (!ok || count_diffs() !== 0 || pkt_cnt !== '0) begin tests_failed++; $display("[TB] FAIL midstall_packet: got %0d diffs cnt=%0d want 0 diffs cnt=0", count_diffs(), pkt_cnt); end
        stall = 1'b0;
    endtask

    task automatic test_oversize();
        bit ok;
        int rdy_33;
        clear_model();
        stall    = 1'b0;
        drop_cnt = 0;
        ready_low = 0;
        push_pkt(33, 0);
        rdy_33 = ready_low;
        push_pkt(36, 0);
        push_pkt(2, 0);
        wait_drain(ok);
        tests_run++;
        if (rdy_33 !== 0) begin tests_failed++; $display("[TB] FAIL oversize_ready: got in_ready low=%0d want 0", rdy_33); end
        tests_run++;
        if (drop_cnt !== 2) begin tests_failed++; $display("[TB] FAIL oversize_drop: got %0d drop cycles want 2", drop_cnt); end
        tests_run++;
        if (!ok || count_diffs() !== 0) begin tests_failed++; $display("[TB] FAIL oversize_next_pkt: got %0d diffs want 0", count_diffs()); end

        // A packet of exactly DEPTH words is the largest that fits.
        clear_model();
        push_pkt(DEPTH, 0);
        wait_drain(ok);
        tests_run++;
        if (!ok || count_diffs() !== 0 || drop_cnt !== 2) begin tests_failed++; $display("[TB] FAIL max_len_pkt: got %0d diffs drops=%0d want 0 diffs drops=2", count_diffs(), drop_cnt); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_model();
        stall = 1'b0;
        for (int i = 0; i < 6; i++) push_word($urandom, i == 5);
        push_word(32'h11111111, 1'b0);
        tests_run++;
        if (o_start !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid_sending: got start=%b want 1", o_start); end
        in_valid = 1'b1;
        in_data  = 32'h22222222;
        in_last  = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (o_data !== '0 || o_start !== 1'b0 || o_end !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_outputs: got data=%h start=%b end=%b want 0 0 0", o_data, o_start, o_end); end
        tests_run++;
        if (pkt_cnt !== '0 || in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid_state: got cnt=%0d ready=%b want 0 1", pkt_cnt, in_ready); end
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        @(negedge clk);
        clear_model();
        push_pkt(2, 0);
        wait_drain(ok);
        tests_run++;
        if (!ok || count_diffs() !== 0) begin tests_failed++; $display("[TB] FAIL rstmid_recover: got %0d diffs want 0", count_diffs()); end
    endtask

    task automatic test_random();
        bit ok;
        clear_model();
        min_gap     = 1000;
        proto_err   = 0;
        drv_timeout = 0;
        rand_stall_en = 1;
        for (int p = 0; p < 25; p++) push_pkt($urandom_range(1, 12), 1);
        rand_stall_en = 0;
        stall = 1'b0;
        wait_drain(ok);
        tests_run++;
        if (!ok || count_diffs() !== 0) begin tests_failed++; $display("[TB] FAIL random_packets: got %0d diffs (%0d of %0d pkts) want 0", count_diffs(), rx_lens.size(), exp_lens.size()); end
        tests_run++;
        if (min_gap < EXP_GAP) begin tests_failed++; $display("[TB] FAIL random_spacing: got min gap %0d want >= %0d", min_gap, EXP_GAP); end
        tests_run++;
        if (proto_err !== 0 || drv_timeout !== 0) begin tests_failed++; $display("[TB] FAIL random_protocol: got errs=%0d timeout=%b want 0 0", proto_err, drv_timeout); end
        tests_run++;
        if (pkt_cnt !== '0) begin tests_failed++; $display("[TB] FAIL random_cnt_after: got %0d want 0", pkt_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic_packet();
        test_single_word();
        test_back_to_back();
        test_oversize();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
